// File: rtl/d_ff_pipe_chain.sv
// Elastic delay line: DEPTH registers of WIDTH bits with a valid/ready handshake
// per stage, bubble collapse, synchronous flush and a registered occupancy count.
module d_ff_pipe_chain #(
  parameter int              WIDTH     = 32,
  parameter int              DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           out_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;

  // What each stage would load: the previous stage, or the input port for stage 0.
  logic [DEPTH-1:0] v_src;
  logic [WIDTH-1:0] d_src [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic             in_xfer, out_xfer;

  // A stage can load when it is empty or when the stage after it is loading;
  // the chain is evaluated from the output side back to the input side.
  always_comb begin : ready_chain
    logic r;
    r = out_ready_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      r      = ~v_q[k] | r;
      rdy[k] = r;
    end
  end

  assign in_ready_o  = rdy[0] & ~flush_i;
  assign out_valid_o = v_q[DEPTH-1] & ~flush_i;
  assign out_data_o  = d_q[DEPTH-1];
  assign count_o     = count_q;
  assign in_xfer     = in_valid_i & in_ready_o;
  assign out_xfer    = out_valid_o & out_ready_i;

  for (genvar k = 0; k < DEPTH; k++) begin : g_src
    if (k == 0) begin : g_head
      assign v_src[k] = in_xfer;
      assign d_src[k] = in_data_i;
    end else begin : g_body
      assign v_src[k] = v_q[k-1];
      assign d_src[k] = d_q[k-1];
    end
  end

  // NOTE: every signal written here gets a hold default first, so no latch is inferred.
  always_comb begin
    v_d     = v_q;
    count_d = count_q;
    for (int k = 0; k < DEPTH; k++) begin
      d_d[k] = d_q[k];
    end

    if (flush_i) begin
      // Flush kills the valid bits only; data registers keep their contents.
      v_d     = '0;
      count_d = '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (rdy[k]) begin
          v_d[k] = v_src[k];
          if (v_src[k]) begin
            d_d[k] = d_src[k];
          end
        end
      end
      count_d = count_q + CW'(in_xfer) - CW'(out_xfer);
    end
  end

  // NOTE: non-blocking assignments only in sequential logic, so every stage
  // samples the pre-edge value of its neighbour.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      v_q     <= '0;
      count_q <= '0;
      // NOTE: data registers are reset too, since out_data_o must read RESET_VAL after reset.
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= RESET_VAL;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

endmodule

// File: tb/tb_d_ff_pipe_chain.sv
// Directed bench for d_ff_pipe_chain: a vector table against an 8-bit, 3-deep
// chain, plus a hand-written sequence on the 1-bit, 1-deep corner geometry.
module tb_d_ff_pipe_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // 8-bit x 3-deep instance
  logic       a_rst = 1'b1, a_flush = 1'b0, a_iv = 1'b0, a_or = 1'b0;
  logic [7:0] a_id = 8'h00;
  logic       a_ir, a_ov;
  logic [7:0] a_od;
  logic [1:0] a_cnt;

  d_ff_pipe_chain #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5)) u_a (
    .clk        (clk),
    .rst_i      (a_rst),
    .flush_i    (a_flush),
    .in_valid_i (a_iv),
    .in_ready_o (a_ir),
    .in_data_i  (a_id),
    .out_valid_o(a_ov),
    .out_ready_i(a_or),
    .out_data_o (a_od),
    .count_o    (a_cnt)
  );

  // 1-bit x 1-deep instance
  logic b_rst = 1'b1, b_flush = 1'b0, b_iv = 1'b0, b_or = 1'b0, b_id = 1'b0;
  logic b_ir, b_ov, b_od;
  logic b_cnt;

  d_ff_pipe_chain #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b1)) u_b (
    .clk        (clk),
    .rst_i      (b_rst),
    .flush_i    (b_flush),
    .in_valid_i (b_iv),
    .in_ready_o (b_ir),
    .in_data_i  (b_id),
    .out_valid_o(b_ov),
    .out_ready_i(b_or),
    .out_data_o (b_od),
    .count_o    (b_cnt)
  );

  typedef struct {
    logic       rst, flush, iv;
    logic [7:0] id;
    logic       ordy, chk;
    logic       e_ir, e_ov;
    logic [7:0] e_od;
    logic [1:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs applied for one cycle; expected outputs are those seen before the next edge.
  task automatic add(input logic rst, input logic flush, input logic iv, input logic [7:0] id,
                     input logic ordy, input logic chk, input logic e_ir, input logic e_ov,
                     input logic [7:0] e_od, input logic [1:0] e_cnt);
    vec_t v;
    v.rst = rst; v.flush = flush; v.iv = iv; v.id = id; v.ordy = ordy; v.chk = chk;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic b_step(input string tag, input logic rst, input logic flush, input logic iv,
                        input logic id, input logic ordy, input logic e_ir, input logic e_ov,
                        input logic e_od, input logic e_cnt);
    @(negedge clk);
    b_rst = rst; b_flush = flush; b_iv = iv; b_id = id; b_or = ordy;
    #1;
    check({tag, " ir"}, b_ir, e_ir);
    check({tag, " ov"}, b_ov, e_ov);
    check({tag, " od"}, b_od, e_od);
    check({tag, " cnt"}, b_cnt, e_cnt);
  endtask

  initial begin
    //   rst fl iv  id    or chk ir ov  od    cnt
    add(1, 0, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0);   // reset hold, state not yet defined
    add(1, 0, 0, 8'h00, 0, 1,  1, 0, 8'hA5, 0);
    add(0, 0, 0, 8'h00, 1, 1,  1, 0, 8'hA5, 0);
    // streaming 01..0A: 01 visible after its third edge, then one per cycle
    add(0, 0, 1, 8'h01, 1, 1,  1, 0, 8'hA5, 0);
    add(0, 0, 1, 8'h02, 1, 1,  1, 0, 8'hA5, 1);
    add(0, 0, 1, 8'h03, 1, 1,  1, 0, 8'hA5, 2);
    for (int i = 4; i <= 10; i++) begin
      add(0, 0, 1, 8'(i), 1, 1, 1, 1, 8'(i - 3), 3);
    end
    add(0, 0, 0, 8'h00, 1, 1,  1, 1, 8'h08, 3);
    add(0, 0, 0, 8'h00, 1, 1,  1, 1, 8'h09, 2);
    add(0, 0, 0, 8'h00, 1, 1,  1, 1, 8'h0A, 1);
    add(0, 0, 0, 8'h00, 1, 1,  1, 0, 8'h0A, 0);
    // backpressure fill
    add(0, 0, 1, 8'h11, 0, 1,  1, 0, 8'h0A, 0);
    add(0, 0, 1, 8'h22, 0, 1,  1, 0, 8'h0A, 1);
    add(0, 0, 1, 8'h33, 0, 1,  1, 0, 8'h0A, 2);
    add(0, 0, 1, 8'h44, 0, 1,  0, 1, 8'h11, 3);
    add(0, 0, 1, 8'h44, 0, 1,  0, 1, 8'h11, 3);
    add(0, 0, 1, 8'h44, 1, 1,  1, 1, 8'h11, 3);   // 44 in as 11 leaves
    add(0, 0, 0, 8'h00, 0, 1,  0, 1, 8'h22, 3);
    add(0, 0, 0, 8'h00, 1, 1,  1, 1, 8'h22, 3);
    add(0, 0, 0, 8'h00, 1, 1,  1, 1, 8'h33, 2);
    add(0, 0, 0, 8'h00, 1, 1,  1, 1, 8'h44, 1);
    // bubble collapse
    add(0, 0, 1, 8'hC1, 0, 1,  1, 0, 8'h44, 0);
    add(0, 0, 0, 8'h00, 0, 1,  1, 0, 8'h44, 1);
    add(0, 0, 0, 8'h00, 0, 1,  1, 0, 8'h44, 1);
    add(0, 0, 1, 8'hC2, 0, 1,  1, 1, 8'hC1, 1);
    add(0, 0, 0, 8'h00, 0, 1,  1, 1, 8'hC1, 2);
    add(0, 0, 0, 8'h00, 0, 1,  1, 1, 8'hC1, 2);
    add(0, 0, 0, 8'h00, 1, 1,  1, 1, 8'hC1, 2);
    add(0, 0, 0, 8'h00, 1, 1,  1, 1, 8'hC2, 1);
    // flush while full, with input offered
    add(0, 0, 1, 8'hD1, 0, 1,  1, 0, 8'hC2, 0);
    add(0, 0, 1, 8'hD2, 0, 1,  1, 0, 8'hC2, 1);
    add(0, 0, 1, 8'hD3, 0, 1,  1, 0, 8'hC2, 2);
    add(0, 1, 1, 8'hFF, 1, 1,  0, 0, 8'hD1, 3);
    add(0, 0, 0, 8'h00, 1, 1,  1, 0, 8'hD1, 0);
    add(0, 0, 0, 8'h00, 1, 1,  1, 0, 8'hD1, 0);
    // reset and flush together while full
    add(0, 0, 1, 8'hE1, 0, 1,  1, 0, 8'hD1, 0);
    add(0, 0, 1, 8'hE2, 0, 1,  1, 0, 8'hD1, 1);
    add(0, 0, 1, 8'hE3, 0, 1,  1, 0, 8'hD1, 2);
    add(0, 0, 0, 8'h00, 0, 1,  0, 1, 8'hE1, 3);
    add(1, 1, 1, 8'h77, 1, 1,  0, 0, 8'hE1, 3);
    add(0, 0, 0, 8'h00, 1, 1,  1, 0, 8'hA5, 0);
    add(0, 0, 1, 8'h5A, 1, 1,  1, 0, 8'hA5, 0);
    add(0, 0, 0, 8'h00, 1, 1,  1, 0, 8'hA5, 1);
    add(0, 0, 0, 8'h00, 1, 1,  1, 0, 8'hA5, 1);
    add(0, 0, 0, 8'h00, 1, 1,  1, 1, 8'h5A, 1);
    add(0, 0, 0, 8'h00, 1, 1,  1, 0, 8'h5A, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      a_rst = vecs[i].rst; a_flush = vecs[i].flush; a_iv = vecs[i].iv;
      a_id = vecs[i].id; a_or = vecs[i].ordy;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("v%0d in_ready", i), a_ir, vecs[i].e_ir);
        check($sformatf("v%0d out_valid", i), a_ov, vecs[i].e_ov);
        check($sformatf("v%0d out_data", i), a_od, vecs[i].e_od);
        check($sformatf("v%0d count", i), a_cnt, vecs[i].e_cnt);
      end
    end

    // Depth-1 corner: the 1-bit chain has been held in reset until now.
    //      tag   rst fl iv id or  ir ov od cnt
    b_step("b1",  0, 0, 0, 0, 0,  1, 0, 1, 0);
    b_step("b2",  0, 0, 1, 0, 0,  1, 0, 1, 0);
    b_step("b3",  0, 0, 1, 1, 0,  0, 1, 0, 1);   // full, no room
    b_step("b4",  0, 0, 1, 1, 1,  1, 1, 0, 1);   // ready passes straight through
    b_step("b5",  0, 0, 1, 0, 1,  1, 1, 1, 1);
    b_step("b6",  0, 0, 0, 0, 0,  0, 1, 0, 1);
    b_step("b7",  1, 1, 1, 0, 1,  0, 0, 0, 1);   // reset wins over flush
    b_step("b8",  0, 0, 0, 0, 0,  1, 0, 1, 0);
    b_step("b9",  0, 0, 1, 0, 0,  1, 0, 1, 0);
    b_step("b10", 0, 1, 1, 1, 1,  0, 0, 0, 1);   // flush alone keeps data
    b_step("b11", 0, 0, 0, 0, 0,  1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/d_ff_pipe_chain.md
Name: d_ff_pipe_chain

Overview:
- Parametrised successor to the single-bit D flip-flop primitive: a chain of DEPTH registers, each WIDTH bits wide, with a valid/ready handshake at every stage.
- Used wherever the datapath needs a fixed-depth retiming or delay line that must also tolerate downstream backpressure, e.g. between decode and execute or on bus return paths.
- Bubbles collapse, so a stalled output stage does not freeze stages that are empty.
- Also provides a synchronous flush and an occupancy count.

Parameters:
- WIDTH, 32, data bits per stage (>=1)
- DEPTH, 2, number of register stages (>=1)
- RESET_VAL, '0, value loaded into every data register on reset (WIDTH bits)

Ports:
- clk  in  1  rising-edge clock
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  synchronous flush: invalidate all stages
- in_valid_i  in  1  upstream data valid
- in_ready_o  out  1  chain accepts in_data_i this cycle
- in_data_i  in  WIDTH  upstream data
- out_valid_o  out  1  last stage holds valid data
- out_ready_i  in  1  downstream accepts out_data_o
- out_data_o  out  WIDTH  last-stage data
- count_o  out  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- State per stage k (0..DEPTH-1): v[k] (1 bit) and d[k] (WIDTH bits). Stage 0 is the input side; stage DEPTH-1 drives the outputs.
- Reset: when rst_i is high at a clk edge, all v[k]=0, all d[k]=RESET_VAL, count=0.
  - Outputs after reset: out_valid_o=0, out_data_o=RESET_VAL, count_o=0, in_ready_o=1 (unless flush_i is high).
  - rst_i has priority over flush_i and over any transfer.
- Ready chain (combinational):
  - rdy[DEPTH] = out_ready_i.
  - rdy[k] = !v[k] | rdy[k+1].
  - in_ready_o = rdy[0] & !flush_i.
- Transfers:
  - Stage k loads from k-1 (or from the input when k=0) when rdy[k]=1.
  - New v[k] = v[k-1]; for stage 0, new v[0] = in_valid_i & in_ready_o.
  - d[k] updates only when rdy[k]=1 and the incoming valid is 1. Otherwise d[k] holds, so no data toggling occurs on bubbles.
- Output handshake:
  - out_valid_o = v[DEPTH-1] & !flush_i.
  - out_data_o = d[DEPTH-1].
  - A transfer out occurs when out_valid_o & out_ready_i.
- Latency and throughput:
  - An item accepted at edge N appears on out_valid_o after edge N+DEPTH-1 (i.e. DEPTH edges to reach stage DEPTH-1), provided no stall.
  - Sustained throughput is 1 item/cycle with out_ready_i=1.
- Backpressure:
  - While out_ready_i=0 and all stages are valid, in_ready_o=0 and every d/v holds.
  - If any stage is empty, the upstream stages advance into it (bubble collapse).
- Flush:
  - flush_i=1 at an edge forces all v[k]=0 and count=0; d[k] are unchanged.
  - During the flush cycle in_ready_o=0 and out_valid_o=0, so no handshake completes on either side.
  - Input presented during flush is dropped.
- count_o:
  - Registered; equals the popcount of v[] at all times.
  - Next count = count + in_xfer - out_xfer, where in_xfer and out_xfer are single-cycle pulses; it is 0 after flush or reset.
  - Simultaneous in and out transfers leave count unchanged.
  - Never exceeds DEPTH and never goes below 0.
- Full/empty:
  - count_o==DEPTH with out_ready_i=0 means in_ready_o=0.
  - count_o==DEPTH with out_ready_i=1 allows simultaneous accept and emit.
  - count_o==0 means out_valid_o=0.
- Order: items leave strictly in acceptance order; none is duplicated or lost except by flush or reset.
- Data-independence: no X propagation from in_data_i into control; valid bits never depend on data.
- DEPTH=1: a single elastic register with combinational pass-through of out_ready_i to in_ready_o when full.

Test Plan:
- Reset: WIDTH=8, DEPTH=3, RESET_VAL=8'hA5, hold rst_i 2 cycles -> out_valid_o=0, out_data_o=8'hA5, count_o=0, in_ready_o=1.
- Streaming: out_ready_i=1, push 8'h01..8'h0A on consecutive cycles -> 8'h01 valid at output 3 edges after acceptance, then one item per cycle in order, count_o stable at 3.
- Backpressure fill: out_ready_i=0, push 8'h11,8'h22,8'h33,8'h44 -> first three accepted, in_ready_o=0 on 4th, count_o=3, out_data_o=8'h11 held. Release out_ready_i -> 8'h44 accepted on the same edge 8'h11 leaves, count_o stays 3.
- Bubble collapse: push 8'hC1, idle 2 cycles, push 8'hC2 with out_ready_i=0 -> C2 advances to stage 1 behind C1, count_o=2, output order C1 then C2.
- Flush mid-stream: chain full (count_o=3), assert flush_i with in_valid_i=1 / in_data_i=8'hFF -> that cycle in_ready_o=0 and out_valid_o=0; next cycle count_o=0 and 8'hFF never emerges.
- Reset vs flush priority: rst_i and flush_i high together while full -> data returns to RESET_VAL (not retained), count_o=0; repeat with DEPTH=1 and WIDTH=1 for the corner geometry.
